// File: rtl/jtkcpu_stack_seq.sv
// Byte sequencer for stack push/pull postbyte instructions (PSHS/PSHU/PULS/PULU).
// Define JTKCPU_STACK_TIMEOUT_EN to abort a stalled bus cycle after 255 cen cycles and flag err.
module jtkcpu_stack_seq (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       start,
  input  logic       is_pull,
  input  logic       ussel_in,
  input  logic [7:0] mask,
  input  logic [7:0] psh_mux,
  input  logic [7:0] mem_din,
  input  logic       mem_ack,
  output logic [7:0] psh_sel,
  output logic       psh_hilon,
  output logic       psh_ussel,
  output logic       dec_us,
  output logic       pul_en,
  output logic       mem_req,
  output logic       mem_we,
  output logic [7:0] mem_dout,
  output logic [7:0] pul_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] byte_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DEC  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_WB   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic       pull_q, pull_d;
  logic       ussel_q, ussel_d;
  logic       half_q, half_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] pdata_q, pdata_d;

  logic [7:0] cur_s;
  logic       is16_s;
  logic [7:0] mask_left_s;
  state_t     next_xfer_s;
  state_t     bd_state_s;
  logic [7:0] bd_mask_s;
  logic       bd_half_s;
  logic [3:0] bd_cnt_s;

`ifdef JTKCPU_STACK_TIMEOUT_EN
  logic [7:0] to_q, to_d;
  logic       err_q, err_d;
`endif

  function automatic logic [7:0] f_top_bit(input logic [7:0] m);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 8; i++) begin
      r = m[i] ? (8'd1 << i) : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] f_low_bit(input logic [7:0] m);
    return m & (~m + 8'd1);
  endfunction

  // Pushes go PC first (highest bit); pulls go CC first (lowest bit).
  assign cur_s       = pull_q ? f_low_bit(mask_q) : f_top_bit(mask_q);
  assign is16_s      = |cur_s[7:4];
  assign mask_left_s = mask_q & ~cur_s;
  assign next_xfer_s = pull_q ? ST_RD : ST_DEC;

  assign busy      = (state_q != ST_IDLE);
  assign psh_sel   = busy ? (pull_q ? mask_q : cur_s) : 8'd0;
  assign psh_hilon = busy & is16_s & (pull_q ? ~half_q : half_q);
  assign psh_ussel = busy & ussel_q;
  assign dec_us    = cen & (state_q == ST_DEC);
  assign pul_en    = cen & (state_q == ST_WB);
  assign done      = cen & (state_q == ST_DONE);
  assign mem_req   = (state_q == ST_WR) | (state_q == ST_RD);
  assign mem_we    = (state_q == ST_WR);
  assign mem_dout  = dout_q;
  assign pul_data  = pdata_q;
  assign byte_cnt  = cnt_q;
`ifdef JTKCPU_STACK_TIMEOUT_EN
  assign err       = cen & (state_q == ST_DONE) & err_q;
`else
  assign err       = 1'b0;
`endif

  // Byte-done bookkeeping shared by the WR and WB states.
  always_comb begin
    bd_cnt_s = (cnt_q == 4'd12) ? 4'd12 : cnt_q + 4'd1;
    if (is16_s && !half_q) begin
      bd_half_s  = 1'b1;
      bd_mask_s  = mask_q;
      bd_state_s = next_xfer_s;
    end else begin
      bd_half_s  = 1'b0;
      bd_mask_s  = mask_left_s;
      bd_state_s = (mask_left_s == 8'd0) ? ST_DONE : next_xfer_s;
    end
  end

  // Next-state logic; everything holds while cen is low.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    pull_d  = pull_q;
    ussel_d = ussel_q;
    half_d  = half_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    pdata_d = pdata_q;
`ifdef JTKCPU_STACK_TIMEOUT_EN
    to_d    = mem_req ? to_q : 8'd0;
    err_d   = err_q;
`endif
    if (!cen) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_d  = mask;
            pull_d  = is_pull;
            ussel_d = ussel_in;
            half_d  = 1'b0;
            cnt_d   = 4'd0;
            state_d = (mask == 8'd0) ? ST_DONE : (is_pull ? ST_RD : ST_DEC);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEC: begin
          dout_d  = psh_mux;
          state_d = ST_WR;
        end
        ST_WR, ST_RD: begin
          if (mem_ack) begin
            if (state_q == ST_RD) begin
              pdata_d = mem_din;
              state_d = ST_WB;
            end else begin
              state_d = bd_state_s;
              mask_d  = bd_mask_s;
              half_d  = bd_half_s;
              cnt_d   = bd_cnt_s;
            end
          end else begin
`ifdef JTKCPU_STACK_TIMEOUT_EN
            if (to_q == 8'd254) begin
              state_d = ST_DONE;
              err_d   = 1'b1;
              mask_d  = 8'd0;
              half_d  = 1'b0;
            end else begin
              to_d = to_q + 8'd1;
            end
`else
            state_d = state_q;
`endif
          end
        end
        ST_WB: begin
          state_d = bd_state_s;
          mask_d  = bd_mask_s;
          half_d  = bd_half_s;
          cnt_d   = bd_cnt_s;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
`ifdef JTKCPU_STACK_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset aborts any bus cycle silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= 8'd0;
      pull_q  <= 1'b0;
      ussel_q <= 1'b0;
      half_q  <= 1'b0;
      cnt_q   <= 4'd0;
      dout_q  <= 8'd0;
      pdata_q <= 8'd0;
`ifdef JTKCPU_STACK_TIMEOUT_EN
      to_q    <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pull_q  <= pull_d;
      ussel_q <= ussel_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      pdata_q <= pdata_d;
`ifdef JTKCPU_STACK_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Scoreboard bench for jtkcpu_stack_seq: expected bytes are queued when a transfer
// is started and popped as writes complete or pull strobes fire.
module tb_jtkcpu_stack_seq;

  logic       clk = 1'b0;
  logic       rst, cen, start, is_pull, ussel_in;
  logic [7:0] mask, psh_mux, mem_din;
  logic       mem_ack;
  logic [7:0] psh_sel;
  logic       psh_hilon, psh_ussel, dec_us, pul_en, mem_req, mem_we;
  logic [7:0] mem_dout, pul_data;
  logic       busy, done, err;
  logic [3:0] byte_cnt;

  always #5 clk = ~clk;

  jtkcpu_stack_seq dut (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .is_pull(is_pull),
    .ussel_in(ussel_in), .mask(mask), .psh_mux(psh_mux), .mem_din(mem_din),
    .mem_ack(mem_ack), .psh_sel(psh_sel), .psh_hilon(psh_hilon),
    .psh_ussel(psh_ussel), .dec_us(dec_us), .pul_en(pul_en), .mem_req(mem_req),
    .mem_we(mem_we), .mem_dout(mem_dout), .pul_data(pul_data), .busy(busy),
    .done(done), .err(err), .byte_cnt(byte_cnt)
  );

  typedef struct packed {
    logic [7:0] sel;
    logic       hilon;
    logic [7:0] data;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] rd_data[8];
  int         rd_idx, wait_cnt, ack_delay;
  logic       ack_never, cen_alt, exp_us;
  logic       in_wr;
  logic [7:0] wr_hold;
  int n_cmp = 0, n_bad = 0;
  int n_dec, n_wr, n_pul, n_done, n_err, n_req, n_req_cen;

  // Register-file model: identifies the selected register, byte half and stack.
  function automatic logic [7:0] reg_model(input logic [7:0] sel, input logic hl, input logic us);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) idx = i[2:0];
    end
    return {idx, hl, us, 3'b101};
  endfunction

  assign psh_mux = reg_model(psh_sel, psh_hilon, psh_ussel);
  assign mem_din = rd_data[rd_idx[2:0]];
  assign mem_ack = mem_req && !ack_never && (wait_cnt >= ack_delay);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_counts();
    n_dec = 0; n_wr = 0; n_pul = 0; n_done = 0; n_err = 0; n_req = 0; n_req_cen = 0;
    rd_idx = 0;
  endtask

  task automatic plan_push(input logic [7:0] m, input logic us);
    rec_t r;
    for (int b = 7; b >= 0; b--) begin
      if (m[b]) begin
        r.sel = 8'd1 << b;
        r.hilon = 1'b0;
        r.data = reg_model(r.sel, 1'b0, us);
        exp_q.push_back(r);
        if (b >= 4) begin
          r.hilon = 1'b1;
          r.data = reg_model(r.sel, 1'b1, us);
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic plan_pull(input logic [7:0] m);
    rec_t r;
    logic [7:0] rem;
    int k;
    rem = m;
    k = 0;
    for (int b = 0; b < 8; b++) begin
      if (m[b]) begin
        r.sel = rem;
        if (b >= 4) begin
          r.hilon = 1'b1; r.data = rd_data[k]; k++; exp_q.push_back(r);
        end
        r.hilon = 1'b0; r.data = rd_data[k]; k++; exp_q.push_back(r);
        rem[b] = 1'b0;
      end
    end
  endtask

  // One clock: observe at the falling edge, update bus model and drive after the rising edge.
  task automatic tick();
    rec_t r;
    logic ack_now, req_now;
    @(negedge clk);
    if (dec_us) n_dec++;
    if (done) n_done++;
    if (err) n_err++;
    if (mem_req) n_req++;
    if (mem_req && cen) n_req_cen++;
    if (mem_req && mem_we) begin
      if (in_wr) check_val("dout_stable", 32'(mem_dout), 32'(wr_hold));
      else begin in_wr = 1'b1; wr_hold = mem_dout; end
    end else begin
      in_wr = 1'b0;
    end
    if (cen && mem_req && mem_we && mem_ack) begin
      n_wr++;
      if (exp_q.size() == 0) check_val("wr_extra", 32'd1, 32'd0);
      else begin
        r = exp_q.pop_front();
        check_val("wr_sel", 32'(psh_sel), 32'(r.sel));
        check_val("wr_hilon", 32'(psh_hilon), 32'(r.hilon));
        check_val("wr_dout", 32'(mem_dout), 32'(r.data));
        check_val("wr_ussel", 32'(psh_ussel), 32'(exp_us));
      end
    end
    if (pul_en) begin
      n_pul++;
      if (exp_q.size() == 0) check_val("pul_extra", 32'd1, 32'd0);
      else begin
        r = exp_q.pop_front();
        check_val("pul_sel", 32'(psh_sel), 32'(r.sel));
        check_val("pul_hilon", 32'(psh_hilon), 32'(r.hilon));
        check_val("pul_data", 32'(pul_data), 32'(r.data));
      end
    end
    ack_now = cen && mem_req && mem_ack;
    req_now = mem_req;
    @(posedge clk);
    #2;
    wait_cnt = (req_now && !ack_now) ? wait_cnt + 1 : 0;
    if (ack_now && !mem_we) rd_idx++;
    if (cen_alt) cen = ~cen;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int d0;
    d0 = n_done;
    for (int i = 0; i < max_cyc && n_done == d0; i++) tick();
    check_val(tag, n_done - d0, 32'd1);
  endtask

  task automatic kick(input logic pull, input logic us, input logic [7:0] m, input int hold);
    is_pull = pull; ussel_in = us; mask = m; exp_us = us;
    start = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; start = 1'b0; is_pull = 1'b0; ussel_in = 1'b0; mask = 8'd0;
    ack_never = 1'b0; ack_delay = 0; cen_alt = 1'b0; wait_cnt = 0; in_wr = 1'b0;
    wr_hold = 8'd0; exp_us = 1'b0;
    for (int i = 0; i < 8; i++) rd_data[i] = 8'd0;
    clear_counts();
    @(posedge clk); #2;
    tick(); tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_strobes", 32'({done, err, mem_req, mem_we, dec_us, pul_en, psh_hilon, psh_ussel}), 32'd0);
    check_val("rst_sel", 32'(psh_sel), 32'd0);
    check_val("rst_cnt", 32'(byte_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Push 0x86 on U, immediate ack.
    clear_counts();
    plan_push(8'h86, 1'b1);
    kick(1'b0, 1'b1, 8'h86, 1);
    wait_done(100, "a_done");
    repeat (3) tick();
    check_val("a_done_cnt", n_done, 32'd1);
    check_val("a_dec", n_dec, 32'd4);
    check_val("a_wr", n_wr, 32'd4);
    check_val("a_left", exp_q.size(), 32'd0);
    check_val("a_bytes", 32'(byte_cnt), 32'd4);

    // Pull 0x11 on S.
    clear_counts();
    rd_data[0] = 8'h5A; rd_data[1] = 8'h12; rd_data[2] = 8'h34;
    plan_pull(8'h11);
    kick(1'b1, 1'b0, 8'h11, 1);
    wait_done(100, "b_done");
    check_val("b_pul", n_pul, 32'd3);
    check_val("b_left", exp_q.size(), 32'd0);
    check_val("b_dec", n_dec, 32'd0);
    check_val("b_bytes", 32'(byte_cnt), 32'd3);

    // Empty mask goes straight to DONE.
    clear_counts();
    kick(1'b0, 1'b0, 8'h00, 1);
    check_val("c_done_now", 32'(done), 32'd1);
    check_val("c_busy", 32'(busy), 32'd1);
    check_val("c_bytes", 32'(byte_cnt), 32'd0);
    tick();
    check_val("c_done_off", 32'(done), 32'd0);
    check_val("c_idle", 32'(busy), 32'd0);
    check_val("c_no_req", n_req, 32'd0);

    // Push 0x02, ack 3 cycles late, cen alternating, a stray start mid-transfer.
    clear_counts();
    plan_push(8'h02, 1'b1);
    ack_delay = 3; cen_alt = 1'b1; cen = 1'b1;
    kick(1'b0, 1'b1, 8'h02, 2);
    is_pull = 1'b1; mask = 8'hFF; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    wait_done(100, "d_done");
    repeat (4) tick();
    check_val("d_done_cnt", n_done, 32'd1);
    check_val("d_wr", n_wr, 32'd1);
    check_val("d_dec", n_dec, 32'd1);
    check_val("d_left", exp_q.size(), 32'd0);
    check_val("d_bytes", 32'(byte_cnt), 32'd1);
    cen_alt = 1'b0; cen = 1'b1; ack_delay = 0;
    tick();

    // Reset in the middle of a 16-bit push write.
    clear_counts();
    ack_never = 1'b1;
    kick(1'b0, 1'b1, 8'h10, 1);
    for (int i = 0; i < 10 && !(mem_req && mem_we); i++) tick();
    check_val("e_in_wr", 32'(mem_req & mem_we), 32'd1);
    rst = 1'b1;
    tick();
    check_val("e_strobes", 32'({busy, done, err, mem_req, mem_we, dec_us, pul_en, psh_hilon, psh_ussel}), 32'd0);
    check_val("e_sel", 32'(psh_sel), 32'd0);
    check_val("e_dout", 32'(mem_dout), 32'd0);
    check_val("e_pdata", 32'(pul_data), 32'd0);
    check_val("e_bytes", 32'(byte_cnt), 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check_val("e_no_done", n_done, 32'd0);
    exp_q.delete();

    // Bus never acknowledges.
    clear_counts();
    kick(1'b0, 1'b0, 8'h01, 1);
`ifdef JTKCPU_STACK_TIMEOUT_EN
    wait_done(400, "f_done");
    check_val("f_err", n_err, 32'd1);
    check_val("f_wait", n_req_cen, 32'd255);
    check_val("f_idle", 32'(busy), 32'd0);
`else
    repeat (300) tick();
    check_val("f_busy", 32'(busy), 32'd1);
    check_val("f_no_done", n_done, 32'd0);
    check_val("f_no_err", n_err, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif
    ack_never = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtkcpu_stack_seq.md
JTKCPU_STACK_SEQ -- requirements
Module: jtkcpu_stack_seq

Interface
REQ-001 SHALL have `rst`, input, 1 bit: synchronous, active-high reset.
REQ-002 SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have `cen`, input, 1 bit: clock enable; state advances and `mem_ack` is sampled only when `cen`=1.
REQ-004 SHALL have `start`, input, 1 bit: begin a transfer; ignored while `busy`=1.
REQ-005 SHALL have `is_pull`, input, 1 bit: 1 = pull (memory→regs), 0 = push; latched at `start`.
REQ-006 SHALL have `ussel_in`, input, 1 bit: 1 = U stack, 0 = S stack; latched at `start`.
REQ-007 SHALL have `mask`, input, 8 bits: postbyte register mask (b0 CC, b1 A, b2 B, b3 DP, b4 X, b5 Y, b6 U/S, b7 PC); latched at `start`.
REQ-008 SHALL have `psh_mux`, input, 8 bits: byte currently selected by the register file.
REQ-009 SHALL have `mem_din`, input, 8 bits: read data. `mem_ack`, input, 1 bit: bus cycle complete.
REQ-010 SHALL have `psh_sel`, output, 8 bits; `psh_hilon`, output, 1 bit; `psh_ussel`, output, 1 bit: register-file selection controls.
REQ-011 SHALL have `dec_us`, output, 1 bit; `pul_en`, output, 1 bit: stack pointer decrement and pull write strobes.
REQ-012 SHALL have `mem_req`, output, 1 bit; `mem_we`, output, 1 bit; `mem_dout`, output, 8 bits; `pul_data`, output, 8 bits.
REQ-013 SHALL have `busy`, output, 1 bit; `done`, output, 1 bit; `err`, output, 1 bit; `byte_cnt`, output, 4 bits.

Function
REQ-014 SHALL implement the states IDLE, DEC, WR, RD, WB and DONE.
REQ-015 SHALL, in IDLE, on `start`&`cen`: latch `mask`/`is_pull`/`ussel_in` and clear `byte_cnt`; go to DONE if `mask`=0, else to RD (pull) or DEC (push).
REQ-016 SHALL, on push, drive `psh_sel` as one-hot of the highest remaining mask bit; order: PC, U/S, Y, X, DP, B, A, CC.
REQ-017 SHALL, on pull, drive `psh_sel` as the full remaining mask; the lowest bit is served first.
REQ-018 SHALL treat bits 4–7 as 16-bit. Push sequence: `psh_hilon`=0 (low byte), then 1. Pull sequence: `psh_hilon`=1, then 0. For 8-bit registers, `psh_hilon` SHALL be 0.
REQ-019 SHALL, in DEC, assert `dec_us` for exactly one `cen` cycle, register `mem_dout`←`psh_mux`, then go to WR.
REQ-020 SHALL, in WR, hold `mem_req`=1, `mem_we`=1 and `mem_dout` stable until `mem_ack`, then take the byte-done action.
REQ-021 SHALL, in RD, hold `mem_req`=1, `mem_we`=0 until `mem_ack`, latch `pul_data`←`mem_din`, then go to WB.
REQ-022 SHALL, in WB, assert `pul_en` for exactly one `cen` cycle with `pul_data` valid, then take the byte-done action.
REQ-023 SHALL perform the byte-done action as follows: `byte_cnt`+1; if a 16-bit first half, toggle `psh_hilon` and repeat; else clear the bit and reset `psh_hilon`; if the mask is empty go to DONE, else go to DEC/RD.
REQ-024 SHALL, in DONE, pulse `done`=1 for one `cen` cycle, then go to IDLE.
REQ-025 SHALL drive `busy`=1 in all states except IDLE.
REQ-026 SHALL hold `psh_ussel` at the latched stack select while busy.
REQ-027 SHALL saturate `byte_cnt` at 12.
REQ-028 SHALL hold all state and outputs when `cen`=0; strobes SHALL be qualified by `cen`.

Reset
REQ-029 SHALL, on `rst`=1 (any state, including mid-transfer), enter IDLE with every output 0 on the next edge.
REQ-030 SHALL drop any in-flight bus request on reset; no `done` SHALL be issued.

Configuration
REQ-031 SHALL, with `JTKCPU_STACK_TIMEOUT_EN` defined, count `cen` cycles spent in WR/RD without `mem_ack`; at 255, pulse `err` for one cycle, assert `done` and go to IDLE.
REQ-032 SHALL, without `JTKCPU_STACK_TIMEOUT_EN`, tie `err`=0 and wait for `mem_ack` indefinitely.

Verification
REQ-033 SHALL cover: push, mask=0x86, `mem_ack` immediate → `psh_sel` 0x80/lo, 0x80/hi, 0x04, 0x02; 4 `dec_us` and 4 writes; `byte_cnt`=4; one `done`.
REQ-034 SHALL cover: pull, mask=0x11, `mem_din`=0x5A,0x12,0x34 → `psh_sel` 0x11 (CC), then 0x10/hi, 0x10/lo; 3 `pul_en` with `pul_data` 0x5A, 0x12, 0x34.
REQ-035 SHALL cover: `start` with mask=0x00 → no `mem_req`; `done` one `cen` cycle after start; `byte_cnt`=0.
REQ-036 SHALL cover: push mask=0x02, `mem_ack` 3 cycles late, `cen` alternating → `mem_dout` stable throughout WR; `start` during busy ignored.
REQ-037 SHALL cover: `rst` during WR of a 16-bit push → IDLE and all outputs 0 next edge; no `done`.
REQ-038 SHALL cover: with `JTKCPU_STACK_TIMEOUT_EN`, `mem_ack` never asserted → `err` and `done` after 255 `cen` cycles; without it, `busy` stays 1.
